// File: rtl/bcd_pkg.sv
// Shared constants and state type for the sequential binary-to-BCD converter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bcd_pkg;

  localparam logic [3:0] SIGN_NEG  = 4'b1111;
  localparam logic [3:0] SIGN_POS  = 4'b1110;
  localparam logic [3:0] DIG_BLANK = 4'b1110;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Start/done handshake and result bus between the ALU result register and the digit mux.
// Latency: none (wiring only).
// Backpressure: start is only honoured while ready is high; nothing is queued.
interface bcd_seq_converter_if #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [IN_W-1:0]       bin_in;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [3:0]            sign_out;
  logic                  ovf;

  modport master (output start, bin_in, input ready, done, bcd_out, sign_out, ovf);
  modport slave  (input start, bin_in, output ready, done, bcd_out, sign_out, ovf);
endinterface

// File: rtl/bcd_digit_adj.sv
// Shift-add-3 correction for one BCD digit: values 5..9 get +3 before the shift.
// Latency: combinational.
// Backpressure: not applicable.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? (d + 4'd3) : d;
endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter (shift-add-3), one input bit per clock, signed or unsigned.
// Latency: start accepted at edge N, done pulses after edge N+IN_W; a new start is accepted in the done cycle.
// Backpressure: ready is low while converting; start during that time is dropped. Optional `LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  bcd_seq_converter_if.slave bus
);

  localparam int CNT_W = $clog2(IN_W + 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IN_W-1:0]       mag;
  logic [4*DIGITS-1:0]   dig;
  logic                  neg;
  logic                  ovf_acc;

  logic                  ready_q;
  logic                  done_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [3:0]            sign_q;
  logic                  ovf_q;

  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   dig_sh;
  logic [IN_W-1:0]       mag_sh;
  logic                  top_bit;
  logic [4*DIGITS-1:0]   dig_disp;

  // One correction cell per digit ahead of the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (dig[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  // The bit leaving the top digit has nowhere to go; it only feeds the overflow flag.
  assign {top_bit, dig_sh, mag_sh} = {adj, mag, 1'b0};

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;

  // Blank zero digits from the top down until the first nonzero one; digit 0 always shows.
  always_comb begin
    dig_disp  = dig_sh;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead_zero && (dig_sh[4*i +: 4] == 4'd0)) begin
        dig_disp[4*i +: 4] = DIG_BLANK;
      end else begin
        lead_zero = 1'b0;
      end
    end
  end
`else
  assign dig_disp = dig_sh;
`endif

  // Control FSM, datapath shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mag     <= '0;
      dig     <= '0;
      neg     <= 1'b0;
      ovf_acc <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      sign_q  <= SIGN_POS;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Most negative input negates to itself, which read unsigned is the right magnitude.
            mag     <= (SIGNED && bus.bin_in[IN_W-1]) ? -bus.bin_in : bus.bin_in;
            neg     <= SIGNED && bus.bin_in[IN_W-1];
            dig     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CNT_W'(IN_W);
            ready_q <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          dig     <= dig_sh;
          mag     <= mag_sh;
          ovf_acc <= ovf_acc | top_bit;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bcd_q   <= dig_disp;
            sign_q  <= neg ? SIGN_NEG : SIGN_POS;
            ovf_q   <= ovf_acc | top_bit;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.sign_out = sign_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: three builds (signed/5 digits, unsigned/5 digits, unsigned/4 digits) driven in lockstep.
// Latency: each conversion must complete exactly 16 clocks after acceptance.
// Backpressure: start noise during conversion must be ignored; back-to-back start in the done cycle must be taken.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_seq_converter_if #(.IN_W(16), .DIGITS(5)) if0 ();
  bcd_seq_converter_if #(.IN_W(16), .DIGITS(5)) if1 ();
  bcd_seq_converter_if #(.IN_W(16), .DIGITS(4)) if2 ();

  assign if0.start = start;  assign if0.bin_in = bin;
  assign if1.start = start;  assign if1.bin_in = bin;
  assign if2.start = start;  assign if2.bin_in = bin;

  bcd_seq_converter #(.IN_W(16), .DIGITS(5), .SIGNED(1'b1)) u0 (.clk(clk), .reset(reset), .bus(if0));
  bcd_seq_converter #(.IN_W(16), .DIGITS(5), .SIGNED(1'b0)) u1 (.clk(clk), .reset(reset), .bus(if1));
  bcd_seq_converter #(.IN_W(16), .DIGITS(4), .SIGNED(1'b0)) u2 (.clk(clk), .reset(reset), .bus(if2));

  // Single comparison point: count, and report any mismatch.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, overflow when the value needs more digits than exist.
  function automatic void model(input logic [15:0] v, input bit sgn, input int nd,
                                output logic [31:0] bcd, output logic [3:0] sg, output logic ov);
    longint m;
    bit     is_neg;
    is_neg = sgn && v[15];
    m      = is_neg ? (longint'(65536) - longint'(v)) : longint'(v);
    bcd    = '0;
    for (int i = 0; i < nd; i++) begin
      bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    ov = (m != 0);
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = nd - 1; i >= 1; i--) begin
      if (bcd[4*i +: 4] != 4'd0) break;
      bcd[4*i +: 4] = 4'hE;
    end
`endif
    sg = is_neg ? 4'hF : 4'hE;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input logic [15:0] v);
    logic [31:0] eb;
    logic [3:0]  es;
    logic        eo;
    model(v, 1'b1, 5, eb, es, eo);
    chk("s5_bcd",  32'(if0.bcd_out),  eb);
    chk("s5_sign", 32'(if0.sign_out), 32'(es));
    chk("s5_ovf",  32'(if0.ovf),      32'(eo));
    model(v, 1'b0, 5, eb, es, eo);
    chk("u5_bcd",  32'(if1.bcd_out),  eb);
    chk("u5_sign", 32'(if1.sign_out), 32'(es));
    chk("u5_ovf",  32'(if1.ovf),      32'(eo));
    model(v, 1'b0, 4, eb, es, eo);
    chk("u4_bcd",  32'(if2.bcd_out),  eb);
    chk("u4_sign", 32'(if2.sign_out), 32'(es));
    chk("u4_ovf",  32'(if2.ovf),      32'(eo));
  endtask

  // Launch one conversion and wait (bounded) for done; returns in the done cycle with start low.
  task automatic run(input logic [15:0] v, input bit noise);
    int n;
    bit seen;
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 16'($urandom);
    chk("ready_busy", 32'(if0.ready), 32'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        bin   = 16'($urandom);
      end
      tick();
      n++;
      if (if0.done) seen = 1'b1;
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'd16);
    chk("done_u1", 32'(if1.done), 32'd1);
    chk("done_u2", 32'(if2.done), 32'd1);
    chk("ready_done", 32'(if0.ready), 32'd1);
    check_outputs(v);
  endtask

  // After a finished conversion: done must drop and outputs must hold.
  task automatic settle(input logic [15:0] v);
    tick();
    chk("done_pulse", 32'(if0.done), 32'd0);
    check_outputs(v);
  endtask

  initial begin
    logic [15:0] dir [8];
    logic [15:0] r;
    bit          any_done;

    dir = '{16'd1234, 16'hFFFF, 16'h8000, 16'd0, 16'd42, 16'd9999, 16'h7FFF, 16'd10000};

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    chk("rst_ready", 32'(if0.ready),    32'd1);
    chk("rst_done",  32'(if0.done),     32'd0);
    chk("rst_bcd",   32'(if0.bcd_out),  32'd0);
    chk("rst_sign",  32'(if0.sign_out), 32'hE);
    chk("rst_ovf",   32'(if2.ovf),      32'd0);
    reset = 1'b0;
    tick();

    foreach (dir[i]) begin
      run(dir[i], 1'b0);
      settle(dir[i]);
    end

    // Start noise while busy must be dropped.
    for (int i = 0; i < 4; i++) begin
      r = 16'($urandom);
      run(r, 1'b1);
      settle(r);
    end

    // Back-to-back: second start issued in the done cycle.
    r = 16'($urandom);
    run(16'd555, 1'b0);
    run(r, 1'b0);
    settle(r);

    // Abort with reset on the 8th conversion cycle.
    start = 1'b1;
    bin   = 16'hABCD;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ready", 32'(if0.ready),    32'd1);
    chk("abort_done",  32'(if0.done),     32'd0);
    chk("abort_bcd",   32'(if0.bcd_out),  32'd0);
    chk("abort_sign",  32'(if0.sign_out), 32'hE);
    chk("abort_ovf",   32'(if2.ovf),      32'd0);
    any_done = 1'b0;
    repeat (20) begin
      tick();
      if (if0.done) any_done = 1'b1;
    end
    chk("abort_no_done", 32'(any_done), 32'd0);
    run(16'd7, 1'b0);
    settle(16'd7);

    // Random sweep.
    for (int i = 0; i < 30; i++) begin
      r = 16'($urandom);
      run(r, (i % 3) == 0);
      settle(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
